// File: rtl/hkspi_master.sv
// hkspi_master: SPI master for the housekeeping SPI port. It runs read-stream
// (0x40) and write-stream (0x80) transactions of cmd_len data bytes starting
// at cmd_addr. SPI mode 0: sck idles low, sdi changes on falling edges and
// sdo is sampled on rising edges.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | csb high, cmd_ready high, waiting for a command
// SETUP | csb low, sck low for CLK_DIV clocks before the first bit
// CMD   | shifting the 0x80/0x40 command byte
// ADDR  | shifting the start address byte
// DATA  | shifting data bytes (a write can stall here waiting for wr_valid)
// HOLD  | sck low for CLK_DIV clocks after the last falling edge
// GAP   | csb high for GAP_HALF*CLK_DIV clocks, still busy
//
// Ports:
//   clock, resetb                  system clock, async active-low reset
//   cmd_valid/cmd_ready            command handshake (cmd_write, cmd_addr, cmd_len)
//   wr_valid/wr_ready/wr_data      write byte stream, wr_ready marks consumption
//   rd_valid/rd_data               read byte stream, one-cycle valid pulse
//   busy, done                     transaction status, done pulses at csb rise
//   sck, csb, sdi, sdo             SPI pins
module hkspi_master #(
  parameter int CLK_DIV  = 2,
  parameter int GAP_HALF = 2
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_len,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       csb,
  output logic       sdi,
  input  logic       sdo
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam int GW = $clog2(GAP_HALF * CLK_DIV) + 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_HALF * CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_ADDR, S_DATA, S_HOLD, S_GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    len_cnt;
  logic [7:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic [7:0]    addr_q;
  logic          write_q;
  logic          high_ph;
  logic          stall;
  logic          rd_pend;

  logic shifting;
  logic half_end;
  logic byte_end;
  logic last_byte;
  logic next_wr;

  assign shifting  = (state inside {S_CMD, S_ADDR, S_DATA}) && !stall;
  assign half_end  = (cnt == '0);
  assign byte_end  = shifting && high_ph && half_end && (bit_cnt == 3'd0);
  assign last_byte = ((state == S_ADDR) && (len_cnt == 8'd0)) ||
                     ((state == S_DATA) && (len_cnt == 8'd1));
  assign next_wr   = write_q && (state inside {S_ADDR, S_DATA}) && !last_byte;

  // A write byte is taken either right at the falling edge that ends the
  // previous byte, or later while stalled; both load the shifter this cycle.
  assign wr_ready  = wr_valid && ((byte_end && next_wr) || ((state == S_DATA) && stall));

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state     <= S_IDLE;
      cnt       <= '0;
      gap_cnt   <= '0;
      bit_cnt   <= 3'd0;
      len_cnt   <= 8'd0;
      tx_sh     <= 8'd0;
      rx_sh     <= 8'd0;
      addr_q    <= 8'd0;
      write_q   <= 1'b0;
      high_ph   <= 1'b0;
      stall     <= 1'b0;
      rd_pend   <= 1'b0;
      cmd_ready <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sck       <= 1'b0;
      csb       <= 1'b1;
      sdi       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      rd_pend  <= 1'b0;
      if (rd_pend) begin
        rd_valid <= 1'b1;
        rd_data  <= rx_sh;
      end

      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            write_q   <= cmd_write;
            addr_q    <= cmd_addr;
            len_cnt   <= cmd_len;
            csb       <= 1'b0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            cnt       <= HALF_LOAD;
            state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (half_end) begin
            state   <= S_CMD;
            tx_sh   <= write_q ? 8'h80 : 8'h40;
            sdi     <= write_q;
            high_ph <= 1'b0;
            bit_cnt <= 3'd7;
            cnt     <= HALF_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_CMD, S_ADDR, S_DATA: begin
          if (stall) begin
            if (wr_valid) begin
              stall   <= 1'b0;
              tx_sh   <= wr_data;
              sdi     <= wr_data[7];
              cnt     <= HALF_LOAD;
              bit_cnt <= 3'd7;
            end
          end else if (!half_end) begin
            cnt <= cnt - 1'b1;
          end else if (!high_ph) begin
            sck     <= 1'b1;
            high_ph <= 1'b1;
            cnt     <= HALF_LOAD;
            rx_sh   <= {rx_sh[6:0], sdo};
            if ((state == S_DATA) && !write_q && (bit_cnt == 3'd0))
              rd_pend <= 1'b1;
          end else begin
            sck     <= 1'b0;
            high_ph <= 1'b0;
            cnt     <= HALF_LOAD;
            if (bit_cnt != 3'd0) begin
              bit_cnt <= bit_cnt - 1'b1;
              tx_sh   <= {tx_sh[6:0], 1'b0};
              sdi     <= tx_sh[6];
            end else begin
              bit_cnt <= 3'd7;
              if (state == S_DATA)
                len_cnt <= len_cnt - 1'b1;
              if (state == S_CMD) begin
                state <= S_ADDR;
                tx_sh <= addr_q;
                sdi   <= addr_q[7];
              end else if (last_byte) begin
                state <= S_HOLD;
                sdi   <= 1'b0;
              end else begin
                state <= S_DATA;
                if (!write_q) begin
                  tx_sh <= 8'd0;
                  sdi   <= 1'b0;
                end else if (wr_valid) begin
                  tx_sh <= wr_data;
                  sdi   <= wr_data[7];
                end else begin
                  stall <= 1'b1;
                  sdi   <= 1'b0;
                end
              end
            end
          end
        end

        S_HOLD: begin
          if (half_end) begin
            csb     <= 1'b1;
            done    <= 1'b1;
            gap_cnt <= GAP_LOAD;
            state   <= S_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_GAP: begin
          if (gap_cnt == '0) begin
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
